// File: rtl/cpu19_pkg.sv
// cpu19_pkg: definitions shared by the cpu19 ALU path (alu_control, alu_exec_unit).
//   CPU19_WIDTH : default datapath width
//   ITER_CNT_W  : width of the multiply/divide iteration counter
//   op_t        : ALU operation codes (14..31 are illegal)
//   state_t     : execution-unit FSM states
package cpu19_pkg;

    localparam int CPU19_WIDTH = 19;
    localparam int ITER_CNT_W  = 5;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_MUL = 5'd2,
        OP_DIV = 5'd3,
        OP_MOD = 5'd4,
        OP_AND = 5'd5,
        OP_OR  = 5'd6,
        OP_XOR = 5'd7,
        OP_NOT = 5'd8,
        OP_INC = 5'd9,
        OP_DEC = 5'd10,
        OP_SHL = 5'd11,
        OP_SHR = 5'd12,
        OP_CMP = 5'd13
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative unsigned shift-add multiplier / restoring divider.
// One step per clock for WIDTH clocks after i_start.
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_start         : load operands and begin (i_is_div selects divide)
//   i_a, i_b        : multiplier/multiplicand or dividend/divisor
//   o_last          : the step being performed this cycle is the final one
//   o_next_hi/lo    : register contents after this cycle's step; on the final
//                     step {hi,lo} = product, or hi = remainder, lo = quotient
module muldiv_iter
    import cpu19_pkg::*;
#(
    parameter int WIDTH = CPU19_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_next_hi,
    output logic [WIDTH-1:0] o_next_lo
);

    localparam logic [ITER_CNT_W-1:0] LP_LAST = ITER_CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]      r_hi;
    logic [WIDTH-1:0]      r_lo;
    logic [WIDTH-1:0]      r_opnd;
    logic                  r_is_div;
    logic                  r_busy;
    logic [ITER_CNT_W-1:0] r_count;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_rem_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // Multiply: add the multiplicand into hi when lo's LSB is set, then shift
    // {carry,hi,lo} right; the multiplier bits drain out of lo as product
    // bits fill in from the top.
    assign w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

    // Divide: shift the next dividend bit into the partial remainder and keep
    // the subtraction only if it does not go negative. When it is kept the
    // difference is below the divisor, so the low WIDTH bits are exact.
    assign w_rem_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_ge        = (w_rem_shift >= {1'b0, r_opnd});
    assign w_diff      = w_rem_shift[WIDTH-1:0] - r_opnd;

    assign o_next_hi = r_is_div ? (w_ge ? w_diff : w_rem_shift[WIDTH-1:0])
                                : w_add[WIDTH:1];
    assign o_next_lo = r_is_div ? {r_lo[WIDTH-2:0], w_ge}
                                : {w_add[0], r_lo[WIDTH-1:1]};
    assign o_last    = r_busy && (r_count == LP_LAST);

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_busy   <= 1'b0;
            r_count  <= '0;
        end else if (i_start) begin
            r_hi     <= '0;
            r_lo     <= i_a;
            r_opnd   <= i_b;
            r_is_div <= i_is_div;
            r_busy   <= 1'b1;
            r_count  <= '0;
        end else if (r_busy) begin
            r_hi    <= o_next_hi;
            r_lo    <= o_next_lo;
            r_count <= r_count + 1'b1;
            if (r_count == LP_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: valid/ready ALU execution stage of cpu19.
// Single-cycle ops and illegal ops finish one cycle after accept; MUL and
// DIV/MOD (divisor != 0) iterate in muldiv_iter and finish WIDTH+1 cycles
// after accept. The result is held in DONE until out_ready.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operation handshake (ready only in IDLE)
//   operation, a, b       : op code and unsigned operands
//   out_valid / out_ready : result handshake
//   result, zero, carry, err : registered result and status flags
module alu_exec_unit
    import cpu19_pkg::*;
#(
    parameter int WIDTH = CPU19_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             err
);

    state_t           r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_err;
    logic             r_is_mod;

    op_t              w_op;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_divmod;
    logic             w_md_start;
    logic             w_md_last;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_div_res;

    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_val;
    logic             w_carry;
    logic             w_err;
    logic             w_cmp;

    assign w_op        = op_t'(operation);
    assign w_accept    = in_valid && (r_state == ST_IDLE);
    assign w_is_mul    = (w_op == OP_MUL);
    assign w_is_divmod = (w_op == OP_DIV) || (w_op == OP_MOD);
    assign w_md_start  = w_accept && (w_is_mul || (w_is_divmod && (b != '0)));

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_md_start),
        .i_is_div  (w_is_divmod),
        .i_a       (a),
        .i_b       (b),
        .o_last    (w_md_last),
        .o_next_hi (w_md_hi),
        .o_next_lo (w_md_lo)
    );

    assign w_div_res = r_is_mod ? w_md_hi : w_md_lo;

    // Single-cycle datapath. w_val is the arithmetic value the zero flag is
    // taken from; CMP reports flags of a-b but returns a zero result.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_ext   = '0;
        w_val   = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        w_cmp   = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_ext   = {1'b0, a} + {1'b0, b};
                w_val   = w_ext[WIDTH-1:0];
                w_carry = w_ext[WIDTH];
            end
            OP_SUB, OP_CMP: begin
                w_ext   = {1'b0, a} - {1'b0, b};
                w_val   = w_ext[WIDTH-1:0];
                w_carry = w_ext[WIDTH];
                w_cmp   = (w_op == OP_CMP);
            end
            OP_INC: begin
                w_ext   = {1'b0, a} + (WIDTH+1)'(1);
                w_val   = w_ext[WIDTH-1:0];
                w_carry = w_ext[WIDTH];
            end
            OP_DEC: begin
                w_ext   = {1'b0, a} - (WIDTH+1)'(1);
                w_val   = w_ext[WIDTH-1:0];
                w_carry = w_ext[WIDTH];
            end
            OP_AND: w_val = a & b;
            OP_OR:  w_val = a | b;
            OP_XOR: w_val = a ^ b;
            OP_NOT: w_val = ~a;
            OP_SHL: begin
                w_val   = {a[WIDTH-2:0], 1'b0};
                w_carry = a[WIDTH-1];
            end
            OP_SHR: w_val = {1'b0, a[WIDTH-1:1]};
            // Only reaches the result register when the divisor is zero.
            OP_DIV, OP_MOD: begin
                w_val = '1;
                w_err = 1'b1;
            end
            OP_MUL: w_val = '0;
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_err    <= 1'b0;
            r_is_mod <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_is_mod <= (w_op == OP_MOD);
                        if (w_is_mul) begin
                            r_state <= ST_MUL;
                        end else if (w_md_start) begin
                            r_state <= ST_DIV;
                        end else begin
                            r_result <= w_cmp ? '0 : w_val;
                            r_zero   <= (w_val == '0);
                            r_carry  <= w_carry;
                            r_err    <= w_err;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    if (w_md_last) begin
                        r_result <= w_md_lo;
                        r_zero   <= (w_md_lo == '0);
                        r_carry  <= (w_md_hi != '0);
                        r_err    <= 1'b0;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    if (w_md_last) begin
                        r_result <= w_div_res;
                        r_zero   <= (w_div_res == '0);
                        r_carry  <= 1'b0;
                        r_err    <= 1'b0;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign err       = r_err;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases, a reset in
// the middle of a multiply, then randomized operations compared against an
// arithmetic reference model.
module tb_alu_exec_unit;

    localparam int W = 19;
    localparam longint unsigned MASK = (64'd1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   operation;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         err;

    int n_checks = 0;
    int n_pass   = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random traffic on the input side while the unit is busy; must be ignored.
    task automatic drive_garbage();
        in_valid  = 1'($urandom_range(0, 1));
        operation = 5'($urandom);
        a         = W'($urandom);
        b         = W'($urandom);
    endtask

    // Reference model: plain arithmetic on 64-bit values, masked to W bits.
    task automatic model(input int op, input longint unsigned x, input longint unsigned y,
                         output longint unsigned res, output bit z, output bit c,
                         output bit e, output int lat);
        longint unsigned v;
        res = 0; c = 0; e = 0; lat = 1;
        case (op)
            0:  begin v = x + y; res = v & MASK; c = (v > MASK); end
            1:  begin res = (x - y) & MASK; c = (x < y); end
            2:  begin v = x * y; res = v & MASK; c = ((v >> W) != 0); lat = W + 1; end
            3, 4: begin
                if (y == 0) begin
                    res = MASK; e = 1;
                end else begin
                    res = (op == 3) ? (x / y) : (x % y);
                    lat = W + 1;
                end
            end
            5:  res = x & y;
            6:  res = x | y;
            7:  res = x ^ y;
            8:  res = ~x & MASK;
            9:  begin v = x + 1; res = v & MASK; c = (v > MASK); end
            10: begin res = (x - 1) & MASK; c = (x == 0); end
            11: begin res = (x << 1) & MASK; c = ((x >> (W - 1)) & 1) != 0; end
            12: res = x >> 1;
            13: begin res = 0; c = (x < y); end
            default: e = 1;
        endcase
        z = (op == 13) ? (((x - y) & MASK) == 0) : (res == 0);
    endtask

    // Issue one op, measure latency, check outputs, hold for 'hold' cycles of
    // backpressure, then release and check the return to IDLE.
    task automatic run_op(input int op, input longint unsigned x, input longint unsigned y,
                          input int hold, input string tag);
        longint unsigned e_res;
        bit e_z, e_c, e_e;
        int e_lat;
        int lat;
        model(op, x, y, e_res, e_z, e_c, e_e, e_lat);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        operation = 5'(op);
        a         = W'(x);
        b         = W'(y);
        tick();
        lat = 1;
        drive_garbage();
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
            drive_garbage();
        end
        check({tag, ".latency"}, 32'(lat), 32'(e_lat));
        check({tag, ".result"}, 32'(result), 32'(e_res));
        check({tag, ".zero"}, 32'(zero), 32'(e_z));
        check({tag, ".carry"}, 32'(carry), 32'(e_c));
        check({tag, ".err"}, 32'(err), 32'(e_e));
        for (int i = 0; i < hold; i++) begin
            tick();
            drive_garbage();
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_result"}, 32'(result), 32'(e_res));
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".rel_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".rel_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    function automatic longint unsigned pick_val();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return MASK;
            2:       return 1;
            3:       return longint'($urandom_range(0, 15));
            default: return longint'($urandom) & MASK;
        endcase
    endfunction

    initial begin
        bit seen_valid;
        int op;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        operation = '0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.result", 32'(result), 32'd0);
        check("reset.flags", {29'd0, zero, carry, err}, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("reset.in_ready", 32'(in_ready), 32'd1);

        // Directed corner cases
        run_op(0,  64'h7FFFF, 64'h00001, 0, "add_wrap");
        run_op(2,  3, 5, 0, "mul_3x5");
        run_op(2,  64'h40000, 4, 1, "mul_ovf");
        run_op(3,  100, 7, 0, "div_100_7");
        run_op(4,  100, 7, 0, "mod_100_7");
        run_op(3,  100, 0, 0, "div_by0");
        run_op(4,  100, 0, 0, "mod_by0");
        run_op(0,  2, 3, 5, "add_bp");
        run_op(20, 11, 22, 0, "illegal20");
        run_op(13, 9, 9, 0, "cmp_eq");
        run_op(11, 64'h40000, 0, 0, "shl_out");
        run_op(10, 0, 0, 0, "dec_zero");

        // Reset during the 10th cycle of a multiply
        in_valid  = 1'b1;
        operation = 5'd2;
        a         = W'(3);
        b         = W'(5);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.result", 32'(result), 32'd0);
        check("midrst.flags", {29'd0, zero, carry, err}, 32'd0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        seen_valid = 1'b0;
        for (int i = 0; i < W + 5; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrst.no_stale_valid", 32'(seen_valid), 32'd0);
        run_op(1, 5, 7, 0, "sub_after_rst");

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 99) < 90) ? int'($urandom_range(0, 13))
                                              : int'($urandom_range(14, 31));
            run_op(op, pick_val(), pick_val(), int'($urandom_range(0, 3)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
